// File: rtl/pdm_demodulator_if.sv
// Signal bundle between a PDM stream consumer and the pdm_demodulator.
// The master drives run enable and the bitstream; the slave (the
// demodulator) returns the recovered value, its strobe and the busy flag.
interface pdm_demodulator_if #(
  parameter int MOD_WIDTH = 8
);
  logic                 ena;
  logic                 pdm_in;
  logic [MOD_WIDTH-1:0] mod_value;
  logic                 out_strobe;
  logic                 busy;

  modport master (
    output ena,
    output pdm_in,
    input  mod_value,
    input  out_strobe,
    input  busy
  );

  modport slave (
    input  ena,
    input  pdm_in,
    output mod_value,
    output out_strobe,
    output busy
  );
endinterface

// File: rtl/pdm_demodulator.sv
// Pulse density demodulator: counts ones in the PDM stream over windows of
// 2**MOD_WIDTH samples, taken every SAMPLE_DIV system clocks via a
// clock-enable divider, and publishes the saturated count with a strobe.
// Optional feature macro PDM_DEMOD_SYNC_EN: when defined, pdm_in passes
// through a 2-flop synchronizer before it is sampled (for pin inputs).
module pdm_demodulator #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int SAMPLE_DIV = 16,
  parameter int MOD_WIDTH  = 8
) (
  input  logic              clk,
  input  logic              nrst,
  pdm_demodulator_if.slave  bus
);

  localparam int                   DIV_W    = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [DIV_W-1:0]     DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [MOD_WIDTH-1:0] CNT_LAST = '1;

  // Reject unusable configurations at elaboration; CLK_HZ is informational.
  if (SAMPLE_DIV < 1 || CLK_HZ < 1) begin : g_bad_param
    $error("pdm_demodulator: SAMPLE_DIV and CLK_HZ must be >= 1");
  end

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [MOD_WIDTH-1:0] smp_q, smp_d;
  logic [MOD_WIDTH:0]   ones_q, ones_d;
  logic [MOD_WIDTH-1:0] mod_q, mod_d;
  logic                 stb_q, stb_d;

  logic                 bit_s;
  logic                 tick;
  logic [MOD_WIDTH:0]   total;

  // A full window of ones yields 2**MOD_WIDTH, one past the output range.
  function automatic logic [MOD_WIDTH-1:0] sat_count(input logic [MOD_WIDTH:0] v);
    if (v[MOD_WIDTH]) begin
      return '1;
    end
    return v[MOD_WIDTH-1:0];
  endfunction

`ifdef PDM_DEMOD_SYNC_EN
  logic [1:0] sync_q;

  // Two-flop synchronizer; the counted bit lags pdm_in by two clocks.
  always_ff @(posedge clk) begin
    sync_q <= {sync_q[0], bus.pdm_in};
  end

  assign bit_s = sync_q[1];
`else
  assign bit_s = bus.pdm_in;
`endif

  assign tick  = (state_q == RUN) && (div_q == DIV_LAST);
  assign total = ones_q + {{MOD_WIDTH{1'b0}}, bit_s};

  // Next-state logic: divider, window counters, result capture and FSM.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    smp_d   = smp_q;
    ones_d  = ones_q;
    mod_d   = mod_q;
    stb_d   = 1'b0;

    case (state_q)
      IDLE: begin
        div_d  = '0;
        smp_d  = '0;
        ones_d = '0;
        if (bus.ena) begin
          state_d = RUN;
        end
      end

      RUN: begin
        if (tick) begin
          div_d = '0;
          if (smp_q == CNT_LAST) begin
            // Last sample of the window: publish and restart with no gap.
            mod_d  = sat_count(total);
            stb_d  = 1'b1;
            smp_d  = '0;
            ones_d = '0;
          end else begin
            smp_d  = smp_q + 1'b1;
            ones_d = total;
          end
        end else begin
          div_d = div_q + 1'b1;
        end

        // Leaving RUN drops any partial window; a completing window above
        // still publishes because mod_d/stb_d are left untouched here.
        if (!bus.ena) begin
          state_d = IDLE;
          div_d   = '0;
          smp_d   = '0;
          ones_d  = '0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= IDLE;
      div_q   <= '0;
      smp_q   <= '0;
      ones_q  <= '0;
      mod_q   <= '0;
      stb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      smp_q   <= smp_d;
      ones_q  <= ones_d;
      mod_q   <= mod_d;
      stb_q   <= stb_d;
    end
  end

  assign bus.mod_value  = mod_q;
  assign bus.out_strobe = stb_q;
  assign bus.busy       = (state_q == RUN);

endmodule

// File: tb/tb_pdm_demodulator.sv
// Self-checking bench for pdm_demodulator with MOD_WIDTH=4, SAMPLE_DIV=4.
// A sample-level model (clocks since RUN entry, a queue of collected bits)
// predicts outputs every cycle; directed windows pin literal values.
module tb_pdm_demodulator;

  localparam int MW  = 4;
  localparam int SD  = 4;
  localparam int WIN = 1 << MW;
`ifdef PDM_DEMOD_SYNC_EN
  localparam int DLY = 2;
`else
  localparam int DLY = 0;
`endif

  logic clk  = 1'b0;
  logic nrst = 1'b0;

  pdm_demodulator_if #(.MOD_WIDTH(MW)) bus ();

  pdm_demodulator #(
    .CLK_HZ    (100_000_000),
    .SAMPLE_DIV(SD),
    .MOD_WIDTH (MW)
  ) dut (
    .clk (clk),
    .nrst(nrst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit cmp_on = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model
  int hist[$] = '{0, 0, 0};
  int win[$];
  bit m_run   = 1'b0;
  int m_cyc   = 0;
  int exp_mod = 0;
  bit exp_stb = 1'b0;

  always @(posedge clk) begin
    int b;
    int s;
    hist.push_front(int'(bus.pdm_in));
    if (hist.size() > 4) void'(hist.pop_back());
    b = hist[DLY];
    if (!nrst) begin
      m_run   = 1'b0;
      m_cyc   = 0;
      win.delete();
      exp_mod = 0;
      exp_stb = 1'b0;
    end else begin
      exp_stb = 1'b0;
      if (m_run) begin
        m_cyc++;
        if (m_cyc % SD == 0) begin
          win.push_back(b);
          if (win.size() == WIN) begin
            s = 0;
            foreach (win[i]) s += win[i];
            exp_mod = (s > WIN - 1) ? WIN - 1 : s;
            exp_stb = 1'b1;
            win.delete();
          end
        end
        if (!bus.ena) begin
          m_run = 1'b0;
          m_cyc = 0;
          win.delete();
        end
      end else if (bus.ena) begin
        m_run = 1'b1;
        m_cyc = 0;
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (cmp_on) begin
      chk("mod_value", int'(bus.mod_value), exp_mod);
      chk("out_strobe", int'(bus.out_strobe), int'(exp_stb));
      chk("busy", int'(bus.busy), int'(m_run));
    end
  end

  // Hold one sample bit for a full sample period (called at a negedge).
  task automatic send(input logic b);
    bus.pdm_in = b;
    repeat (SD) @(negedge clk);
  endtask

  task automatic window(input logic [15:0] pat, input int exp, input string nm);
    for (int i = 0; i < WIN; i++) send(pat[i]);
    chk({nm, " strobe"}, int'(bus.out_strobe), 1);
    chk({nm, " value"}, int'(bus.mod_value), exp);
  endtask

  initial begin
    bus.ena    = 1'b0;
    bus.pdm_in = 1'b0;
    nrst       = 1'b0;
    repeat (3) @(negedge clk);
    cmp_on = 1'b1;
    chk("reset mod_value", int'(bus.mod_value), 0);
    chk("reset out_strobe", int'(bus.out_strobe), 0);
    chk("reset busy", int'(bus.busy), 0);

    nrst = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle busy", int'(bus.busy), 0);

    // Constant zero, two back-to-back windows.
    bus.ena = 1'b1;
    @(negedge clk);
    chk("run busy", int'(bus.busy), 1);
    window(16'h0000, 0, "zeros w1");
    window(16'h0000, 0, "zeros w2");

    // Constant one saturates.
    window(16'hFFFF, 15, "ones w1");
    window(16'hFFFF, 15, "ones w2");

    // Alternating and sparse patterns.
    window(16'h5555, 8, "alt");
    window(16'b0001_0010_0100_1001, 5, "five");
    window(16'h5555, 8, "alt2");

    // Abort after 7 samples: no strobe, value held.
    for (int i = 0; i < 7; i++) send(i[0] ? 1'b0 : 1'b1);
    bus.ena = 1'b0;
    @(negedge clk);
    chk("abort busy", int'(bus.busy), 0);
    chk("abort strobe", int'(bus.out_strobe), 0);
    chk("abort value", int'(bus.mod_value), 8);
    repeat (10) @(negedge clk);
    chk("abort hold", int'(bus.mod_value), 8);

    // Re-enter with constant one.
    bus.pdm_in = 1'b1;
    bus.ena    = 1'b1;
    @(negedge clk);
    window(16'hFFFF, 15, "reentry");

    // ena falls in the cycle of the final tick.
    for (int i = 0; i < WIN - 1; i++) send(1'b0);
    bus.pdm_in = 1'b0;
    repeat (SD - 1) @(negedge clk);
    bus.ena = 1'b0;
    @(negedge clk);
    chk("fall strobe", int'(bus.out_strobe), 1);
    chk("fall value", int'(bus.mod_value), 0);
    chk("fall busy", int'(bus.busy), 0);
    repeat (4) @(negedge clk);

    // Reset mid-window while mod_value=15.
    bus.ena = 1'b1;
    @(negedge clk);
    window(16'hFFFF, 15, "pre-reset");
    for (int i = 0; i < 5; i++) send(1'b1);
    nrst = 1'b0;
    @(negedge clk);
    chk("midrst value", int'(bus.mod_value), 0);
    chk("midrst strobe", int'(bus.out_strobe), 0);
    chk("midrst busy", int'(bus.busy), 0);
    nrst = 1'b1;
    @(negedge clk);
    chk("post-reset busy", int'(bus.busy), 1);
    window(16'hFFFF, 15, "post-reset");

    bus.ena = 1'b0;
    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pdm_demodulator.md
# pdm_demodulator

Pulse density demodulator: recovers a MOD_WIDTH-bit value from a 1-bit PDM stream by counting ones over fixed windows of 2**MOD_WIDTH samples. The block is the receive-side counterpart of the team's PDM generator. It sits between an external PDM source, such as a loopback pin or a sigma-delta sensor, and any logic that consumes multi-bit setpoints. It runs on the system clock and derives its sample timing from an internal clock-enable divider, not from a derived clock.

## Interface
- CLK_HZ, 100_000_000: system clock frequency; documentation only, no logic depends on it.
- SAMPLE_DIV, 16: system clocks per PDM sample; must be >= 1.
- MOD_WIDTH, 8: output bitness; window length is 2**MOD_WIDTH samples.

- clk  input  1  system clock; all logic on the rising edge.
- nrst  input  1  reset, synchronous, active-low.
- ena  input  1  run enable, level-sensitive.
- pdm_in  input  1  PDM bitstream, active HIGH = 1.
- mod_value  output  MOD_WIDTH  demodulated value of the last completed window; held between updates.
- out_strobe  output  1  one-cycle pulse, asserted in the same cycle mod_value updates.
- busy  output  1  high while in RUN.

## Operation
- State machine with two states.
  - IDLE: divider, sample counter and ones counter are held at 0. On ena=1, move to RUN at the next edge.
  - RUN: divider counts 0..SAMPLE_DIV-1 and wraps; a sample tick occurs when divider==SAMPLE_DIV-1. On ena=0, return to IDLE at the next edge.
- Abort: leaving RUN abandons the partial window and clears all counters. mod_value holds its last value and no strobe is issued.
- On each tick:
  - ones counter (MOD_WIDTH+1 bits) += sampled bit;
  - sample counter (MOD_WIDTH bits) += 1.
- Window end: the tick on which sample counter == 2**MOD_WIDTH-1 completes the window.
  - total = ones + current bit, range 0..2**MOD_WIDTH.
  - mod_value <= min(total, 2**MOD_WIDTH-1); the all-ones window saturates.
  - out_strobe <= 1 for exactly one cycle.
  - Both counters reset, so the next window starts on the next tick with no gap.
- busy = (state==RUN), registered.
- Simultaneous window end and ena falling: the window end completes (value and strobe issued) and the state also goes to IDLE.
- SAMPLE_DIV=1: every RUN cycle is a tick.

## Timing
- Reset (nrst=0 at a rising edge), from any state:
  - state=IDLE, divider=0, counters=0;
  - mod_value=0, out_strobe=0, busy=0 after that edge.
  - Applies mid-window; the partial window is discarded.
- ena=1 sampled at edge N → busy=1 after edge N; first tick occurs SAMPLE_DIV cycles after entering RUN.
- Window period: SAMPLE_DIV*2**MOD_WIDTH clocks; consecutive strobes are exactly this far apart while ena stays high.
- mod_value and out_strobe are registered and update on the edge following the final tick.
- pdm_in-to-count latency: see Configuration.

## Configuration
- PDM_DEMOD_SYNC_EN defined: pdm_in passes through a 2-flop synchronizer before sampling. The bit counted at a tick is pdm_in from 2 clocks earlier. Use this for asynchronous or pin inputs.
- Not defined: pdm_in is sampled directly at the tick. Input must be synchronous to clk.
- mod_value, strobe cadence and state behaviour are otherwise identical in both builds.

## Test plan
Bench parameters: MOD_WIDTH=4, SAMPLE_DIV=4, giving a 64-clock window; each build is run with PDM_DEMOD_SYNC_EN both defined and undefined.
- pdm_in=0 constantly, ena=1 → out_strobe every 64 clocks, first 64 clocks after RUN entry; mod_value=0.
- pdm_in=1 constantly → count 16 saturates; mod_value=15 on every strobe.
- pdm_in toggling every sample (1,0,1,0…), aligned to ticks → mod_value=8; pattern with 5 ones per 16 samples → mod_value=5.
- ena dropped after 7 samples of a window following a window with value 8 → busy=0 next edge, no strobe, mod_value stays 8. Re-asserting ena with constant 1 gives the next strobe 64 clocks after RUN entry, with value 15.
- ena falling in the same cycle as the final tick → strobe and new mod_value are issued, busy=0 after that edge.
- nrst=0 for one edge mid-window while mod_value=15 → mod_value=0, out_strobe=0, busy=0 after that edge. With ena held high, RUN is re-entered next edge and a full 64-clock window is required before the next strobe.
